// File: rtl/fir_mac_if.sv
// Sample/coefficient/result bundle for fir_mac_sequencer.
// master = sample source and coefficient writer, slave = the FIR engine.
interface fir_mac_if #(
    parameter int N_TAPS = 32,
    parameter int DATA_W = 16,
    parameter int COEF_W = 11,
    parameter int ACC_W  = 32
);
    localparam int AW = $clog2(N_TAPS);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] data_in;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     out_valid;
    logic signed [ACC_W-1:0]  data_out;
    logic                     busy;

    modport master (
        output in_valid, data_in, coef_we, coef_addr, coef_wdata,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, data_in, coef_we, coef_addr, coef_wdata,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared MAC stepped across the taps of each accepted sample.
// Optional FIR_SYM_FOLD_EN: symmetric fold, half the coefficients and half the MAC cycles.
//
// state | meaning
// IDLE  | in_ready high, coefficient writes accepted, waiting for a sample
// MAC   | one tap (or folded tap pair) accumulated per cycle
// OUT   | out_valid pulse cycle, data_out holds the result
module fir_mac_sequencer #(
    parameter int N_TAPS = 32,
    parameter int DATA_W = 16,
    parameter int COEF_W = 11,
    parameter int ACC_W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    fir_mac_if.slave     bus
);
    localparam int AW = $clog2(N_TAPS);
`ifdef FIR_SYM_FOLD_EN
    localparam int N_STEPS = N_TAPS / 2;
    localparam int PRE_W   = DATA_W + 1;
`else
    localparam int N_STEPS = N_TAPS;
    localparam int PRE_W   = DATA_W;
`endif
    localparam int PROD_W = PRE_W + COEF_W;
    localparam logic [AW-1:0] K_LAST = AW'(N_STEPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                   state;
    logic signed [DATA_W-1:0] hist [N_TAPS];
    logic signed [COEF_W-1:0] coef [N_TAPS];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            k;
    logic signed [ACC_W-1:0]  acc;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic signed [ACC_W-1:0]  data_out_q;
    logic                     busy_q;

    logic [AW-1:0]            idx_new;
    logic signed [PRE_W-1:0]  pre;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic                     coef_addr_ok;

`ifdef FIR_SYM_FOLD_EN
    logic [AW-1:0] idx_old;

    // Mirror tap n-(N_TAPS-1-k) reduces to wr_ptr+1+k modulo N_TAPS.
    always_comb begin
        idx_new      = wr_ptr - k;
        idx_old      = wr_ptr + k + AW'(1);
        pre          = {hist[idx_new][DATA_W-1], hist[idx_new]}
                     + {hist[idx_old][DATA_W-1], hist[idx_old]};
        coef_addr_ok = (bus.coef_addr < AW'(N_TAPS / 2));
    end
`else
    always_comb begin
        idx_new      = wr_ptr - k;
        pre          = hist[idx_new];
        coef_addr_ok = 1'b1;
    end
`endif

    always_comb begin
        prod     = pre * coef[k];
        prod_ext = ACC_W'(prod);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            busy_q      <= 1'b0;
            wr_ptr      <= '0;
            k           <= '0;
            acc         <= '0;
            for (int i = 0; i < N_TAPS; i++) begin
                hist[i] <= '0;
                coef[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (state == S_IDLE && bus.coef_we && coef_addr_ok)
                coef[bus.coef_addr] <= bus.coef_wdata;
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        hist[wr_ptr] <= bus.data_in;
                        acc          <= '0;
                        k            <= '0;
                        in_ready_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        state        <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + prod_ext;
                    k   <= k + AW'(1);
                    // Result is registered on the last tap so out_valid lines up with OUT.
                    if (k == K_LAST) begin
                        wr_ptr      <= wr_ptr + AW'(1);
                        data_out_q  <= acc + prod_ext;
                        out_valid_q <= 1'b1;
                        state       <= S_OUT;
                    end
                end
                S_OUT: begin
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer against a direct-form convolution model.
module tb_fir_mac_sequencer;
    localparam int N  = 32;
    localparam int DW = 16;
    localparam int CW = 11;
    localparam int AC = 32;
`ifdef FIR_SYM_FOLD_EN
    localparam int STEPS = N / 2;
`else
    localparam int STEPS = N;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_mac_if #(.N_TAPS(N), .DATA_W(DW), .COEF_W(CW), .ACC_W(AC)) bus ();

    fir_mac_sequencer #(.N_TAPS(N), .DATA_W(DW), .COEF_W(CW), .ACC_W(AC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_hist [N];   // m_hist[0] is the newest sample
    int m_coef [N];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int coef_eff(input int k);
`ifdef FIR_SYM_FOLD_EN
        return (k < N / 2) ? m_coef[k] : m_coef[N - 1 - k];
`else
        return m_coef[k];
`endif
    endfunction

    function automatic int model_out();
        longint s = 0;
        for (int k = 0; k < N; k++) s += longint'(m_hist[k]) * longint'(coef_eff(k));
        return int'(s);
    endfunction

    task automatic model_push(input int x);
        for (int k = N - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = x;
    endtask

    task automatic model_wr(input int a, input int v);
`ifdef FIR_SYM_FOLD_EN
        if (a < N / 2) m_coef[a] = v;
`else
        m_coef[a] = v;
`endif
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            m_hist[k] = 0;
            m_coef[k] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        tick();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic write_coef(input int a, input int v);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 5'(a);
        bus.coef_wdata = 11'(v);
        tick();
        bus.coef_we = 1'b0;
        model_wr(a, v);
    endtask

    task automatic run_sample(input int x, input bit wr, input int a, input int v,
                              input string tag, output longint res);
        int lat;
        int exp;
        bit rdy_bad;
        lat = 0;
        while (!bus.in_ready && lat < 200) begin
            tick();
            lat++;
        end
        if (!bus.in_ready) check_val({tag, "_ready_wait"}, longint'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.data_in  = 16'(x);
        if (wr) begin
            bus.coef_we    = 1'b1;
            bus.coef_addr  = 5'(a);
            bus.coef_wdata = 11'(v);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        if (wr) model_wr(a, v);
        model_push(x);
        exp = model_out();
        check_val({tag, "_busy"}, longint'(bus.busy), 1);
        lat = 0;
        rdy_bad = 1'b0;
        while (!bus.out_valid && lat < STEPS + 20) begin
            if (bus.in_ready) rdy_bad = 1'b1;
            tick();
            lat++;
        end
        if (bus.in_ready) rdy_bad = 1'b1;
        check_val({tag, "_latency"}, lat, STEPS);
        check_val({tag, "_data"}, bus.data_out, exp);
        check_val({tag, "_ready_low"}, longint'(rdy_bad), 0);
        res = bus.data_out;
        tick();
        check_val({tag, "_pulse"}, longint'(bus.out_valid), 0);
        check_val({tag, "_ready_back"}, longint'(bus.in_ready), 1);
        check_val({tag, "_hold"}, bus.data_out, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint r;
        int acc_cyc[$];
        int out_cyc[$];
        int exp_q[$];
        int d;
        int c;
        int seen;
        bit acc_now;

        bus.in_valid   = 1'b0;
        bus.data_in    = '0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;

        // Reset state
        do_reset();
        check_val("rst_in_ready", longint'(bus.in_ready), 1);
        check_val("rst_out_valid", longint'(bus.out_valid), 0);
        check_val("rst_data_out", bus.data_out, 0);
        check_val("rst_busy", longint'(bus.busy), 0);

        // Impulse with coef[k] = k+1
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        for (int i = 0; i <= N; i++) run_sample(i == 0 ? 1 : 0, 1'b0, 0, 0, "impulse", r);

        // DC ramp
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, 1);
        for (int i = 0; i < N; i++) run_sample(100, 1'b0, 0, 0, "ramp", r);
        check_val("ramp_full", r, 3200);
        run_sample(-50, 1'b0, 0, 0, "ramp_neg", r);
        check_val("ramp_neg_const", r, 3050);

        // Extremes
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, -1024);
        for (int i = 0; i < N; i++) run_sample(-32768, 1'b0, 0, 0, "extreme", r);
        check_val("extreme_const", r, 1073741824);

        // Handshake: in_valid held high, coef writes attempted while busy
        do_reset();
        write_coef(0, 3);
        write_coef(1, -2);
        d = 1000;
        c = 0;
        bus.in_valid = 1'b1;
        bus.data_in  = 16'(d);
        while (out_cyc.size() < 4 && c < 4 * (STEPS + 2) + 20) begin
            if (bus.out_valid) begin
                out_cyc.push_back(c);
                if (exp_q.size() > 0) check_val("hs_data", bus.data_out, exp_q.pop_front());
                else check_val("hs_unexpected_out", longint'(bus.out_valid), 0);
            end
            bus.coef_we    = bus.busy;
            bus.coef_addr  = 5'(0);
            bus.coef_wdata = 11'(7);
            acc_now = bus.in_ready;
            if (acc_now) begin
                acc_cyc.push_back(c);
                model_push(d);
                exp_q.push_back(model_out());
            end
            tick();
            c++;
            if (acc_now) begin
                d++;
                bus.data_in = 16'(d);
            end
        end
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        check_val("hs_out_count", out_cyc.size(), 4);
        check_val("hs_acc_count", acc_cyc.size(), 4);
        for (int i = 1; i < 4; i++) begin
            if (i < acc_cyc.size()) check_val("hs_acc_spacing", acc_cyc[i] - acc_cyc[i-1], STEPS + 2);
            if (i < out_cyc.size()) check_val("hs_out_spacing", out_cyc[i] - out_cyc[i-1], STEPS + 2);
        end
        for (int i = 0; i < 4; i++)
            if (i < out_cyc.size() && i < acc_cyc.size())
                check_val("hs_latency", out_cyc[i] - acc_cyc[i], STEPS + 1);
        run_sample(1, 1'b0, 0, 0, "coef0_kept", r);
        run_sample(0, 1'b0, 0, 0, "coef0_kept2", r);

        // Reset mid-MAC
        for (int k = 0; k < N; k++) write_coef(k, 5);
        bus.in_valid = 1'b1;
        bus.data_in  = 16'(123);
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        check_val("midrst_in_ready", longint'(bus.in_ready), 1);
        check_val("midrst_busy", longint'(bus.busy), 0);
        seen = 0;
        for (int i = 0; i < STEPS + 4; i++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        check_val("midrst_no_out", seen, 0);
        run_sample(1, 1'b0, 0, 0, "midrst_impulse", r);
        check_val("midrst_zero_coef", r, 0);

        // Randomized traffic with interleaved coefficient writes
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, int'($urandom_range(0, 2047)) - 1024);
        for (int i = 0; i < 48; i++) begin
            if ($urandom_range(0, 3) == 0)
                write_coef(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 2047)) - 1024);
            repeat ($urandom_range(0, 2)) tick();
            run_sample(int'($urandom_range(0, 65535)) - 32768, ($urandom_range(0, 3) == 0),
                       int'($urandom_range(0, N - 1)), int'($urandom_range(0, 2047)) - 1024,
                       "random", r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Time-multiplexed FIR low-pass engine for the sample path. One shared multiply-accumulate unit is stepped across all taps per input sample. Holds a circular sample history and a run-time-writable coefficient bank, accepts samples with a valid/ready handshake, and emits one filtered result per accepted sample. Replaces a fully parallel tap array where throughput allows N+2 cycles per sample.

Parameters:
N_TAPS, 32, number of taps; even, power of two.
DATA_W, 16, signed sample width.
COEF_W, 11, signed coefficient width.
ACC_W, 32, signed accumulator and output width; must be at least DATA_W+COEF_W+log2(N_TAPS).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous active-high reset.
in_valid  in  1  data_in is valid this cycle.
in_ready  out  1  block can accept a sample this cycle.
data_in  in  DATA_W  signed input sample.
coef_we  in  1  coefficient write strobe.
coef_addr  in  log2(N_TAPS)  coefficient index k.
coef_wdata  in  COEF_W  signed coefficient value.
out_valid  out  1  single-cycle pulse; data_out is valid.
data_out  out  ACC_W  signed filter result, held until the next result.
busy  out  1  high in MAC and OUT states.

Behaviour:
- Reset (rst=1 at an edge):
  - state = IDLE; in_ready = 1 on the first cycle after reset.
  - out_valid = 0, data_out = 0, busy = 0.
  - Sample history, write pointer and all coefficients are cleared to 0.
  - Reset overrides every other input.
- FSM states are IDLE, MAC and OUT.
  - IDLE: in_ready = 1.
    - On in_valid & in_ready at edge T: store data_in at wr_ptr, clear the accumulator, set k = 0, go to MAC.
  - MAC: one tap per cycle, k = 0..N_TAPS-1. acc += hist[(wr_ptr - k) mod N_TAPS] * coef[k].
    - k=0 is the newest sample.
    - After the k = N_TAPS-1 update, advance wr_ptr (modulo N_TAPS, wraps) and go to OUT.
  - OUT: register data_out = acc, pulse out_valid for one cycle, return to IDLE.
- Latency:
  - Accept edge T. MAC occupies cycles T+1..T+N_TAPS.
  - out_valid is high in cycle T+N_TAPS+1.
  - in_ready is low from T+1 through T+N_TAPS+1 and high again at T+N_TAPS+2.
  - Throughput is one sample per N_TAPS+2 cycles.
- There is no output back-pressure. out_valid is a pulse and the consumer must capture it.
- Arithmetic:
  - Full signed product, DATA_W+COEF_W bits, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W. No rounding or truncation.
- Coefficient writes:
  - Take effect only in IDLE; coef_we in MAC/OUT is ignored (no queueing).
  - If coef_we and an accepted in_valid occur in the same IDLE cycle, both happen and the new coefficient is used for that sample.
- Startup: the history starts at zero, so the first N_TAPS-1 outputs reflect zero-padded history.
- Reset mid-operation (MAC or OUT): abort, no out_valid for the aborted sample, history and coefficients cleared.

Optional Feature:
Macro FIR_SYM_FOLD_EN.
- Defined: symmetric-fold mode. Only coef[0..N_TAPS/2-1] is used; writes with coef_addr >= N_TAPS/2 are ignored.
  - MAC runs N_TAPS/2 cycles: acc += (hist[n-k] + hist[n-(N_TAPS-1-k)]) * coef[k].
  - The pre-add is DATA_W+1 bits signed.
  - out_valid at T+N_TAPS/2+1; in_ready is high again at T+N_TAPS/2+2.
- Not defined: the general N_TAPS-cycle behaviour above. All coefficient addresses are writable.

Test Plan:
1. Impulse: reset, write coef[k]=k+1 for k=0..31, feed 1 then 31 zeros, then one more 0 → outputs 1,2,...,32 then 0; each out_valid exactly 33 cycles after its accept edge.
2. DC ramp: all coefs = 1, feed 32 samples of 100 → outputs 100,200,...,3200; then feed -50 → 3200-100-50 = 3050.
3. Extremes: all coefs = -1024, feed 32 samples of -32768 → final output 1073741824 (0x40000000), no wrap.
4. Handshake: in_valid held high with an incrementing data_in → exactly one accept per 34 cycles, out_valid pulses spaced 34 cycles apart; coef_we=1 (addr 0, value 7) during MAC leaves coef[0] unchanged, confirmed by a following impulse.
5. Reset mid-MAC: assert rst at T+10 for 1 cycle → no out_valid; in_ready=1 the cycle after reset; coefs read back as 0 (impulse gives output 0).
6. FIR_SYM_FOLD_EN defined: coef[0..15] = -17,-20,-26,-31,-29,-15,20,82,174,294,437,591,741,873,971,1023, then impulse → outputs follow the symmetric 32-tap response (-17,...,1023,1023,...,-17); out_valid at T+17.
